// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry scanner: FSM states,
// key codes and the row/column to key decode.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      EMIT         = 2'd2,
      WAIT_RELEASE = 2'd3
   } kp_state_e;

   localparam logic [3:0] KEY_A     = 4'hA;
   localparam logic [3:0] KEY_B     = 4'hB;
   localparam logic [3:0] KEY_C     = 4'hC;
   localparam logic [3:0] KEY_D     = 4'hD;
   localparam logic [3:0] KEY_STAR  = 4'hE;
   localparam logic [3:0] KEY_HASH  = 4'hF;
   localparam logic [3:0] ROWS_IDLE = 4'hF;

   // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
   function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'h0;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = KEY_A;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = KEY_B;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'h0;
         4'hE: code = KEY_HASH;
         4'hF: code = KEY_D;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic single_low(input logic [3:0] rows);
      return (rows == 4'b1110) || (rows == 4'b1101) ||
             (rows == 4'b1011) || (rows == 4'b0111);
   endfunction

endpackage

// File: rtl/keypad_entry_scanner_row_sync.sv
// Row synchroniser plus a counter of consecutive cycles on which the
// synchronised rows match a reference pattern.
module keypad_row_sync
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 20000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] row_i,
   input  logic [3:0] ref_i,
   input  logic       cnt_en_i,
   input  logic       clr_i,
   output logic [3:0] rows_s_o,
   output logic       stable_done_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [3:0]    meta_q;
   logic [3:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          match;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= ROWS_IDLE;
         sync_q <= ROWS_IDLE;
         cnt_q  <= '0;
      end else begin
         meta_q <= row_i;
         sync_q <= meta_q;
         cnt_q  <= cnt_d;
      end
   end

   assign match         = cnt_en_i && (sync_q == ref_i);
   assign stable_done_o = match && (cnt_q == CNT_LAST);
   assign rows_s_o      = sync_q;

   // Counter holds at its last value rather than wrapping; any mismatch restarts it
   always_comb begin
      cnt_d = '0;
      if (!clr_i && match) begin
         if (cnt_q == CNT_LAST) cnt_d = cnt_q;
         else                   cnt_d = cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner: column scan, debounce, decode and single-cycle
// digit/check/clear strobes toward the password checker.
module keypad_entry_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int NUM_DIGITS   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_in,
   output logic       enter,
   output logic       check,
   output logic       clear,
   output logic [2:0] digit_cnt
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [2:0]    DIG_MAX  = 3'(NUM_DIGITS);

   kp_state_e     state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    latch_q, latch_d;
   logic [3:0]    key_q, key_d;
   logic          enter_q, enter_d;
   logic          check_q, check_d;
   logic          clear_q, clear_d;
   logic [2:0]    dcnt_q, dcnt_d;

   logic [3:0] rows_s;
   logic       stable_done;
   logic [3:0] dec_code;
   logic [3:0] sync_ref;
   logic       sync_en;
   logic       sync_clr;

   keypad_row_sync #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_row_sync (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .row_i         (row_in),
      .ref_i         (sync_ref),
      .cnt_en_i      (sync_en),
      .clr_i         (sync_clr),
      .rows_s_o      (rows_s),
      .stable_done_o (stable_done)
   );

   assign sync_ref = (state_q == WAIT_RELEASE) ? ROWS_IDLE : latch_q;
   assign sync_en  = (state_q == DEBOUNCE) || (state_q == WAIT_RELEASE);
   assign sync_clr = (state_d != state_q);
   assign dec_code = decode_key(low_row_idx(latch_q), col_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCAN;
         col_q   <= 2'd0;
         div_q   <= '0;
         latch_q <= ROWS_IDLE;
         key_q   <= 4'h0;
         enter_q <= 1'b0;
         check_q <= 1'b0;
         clear_q <= 1'b0;
         dcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         div_q   <= div_d;
         latch_q <= latch_d;
         key_q   <= key_d;
         enter_q <= enter_d;
         check_q <= check_d;
         clear_q <= clear_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Strobes are computed on the DEBOUNCE->EMIT transition so they are
   // registered and visible exactly while the FSM sits in EMIT.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      div_d   = '0;
      latch_d = latch_q;
      key_d   = key_q;
      enter_d = 1'b0;
      check_d = 1'b0;
      clear_d = 1'b0;
      dcnt_d  = dcnt_q;
      case (state_q)
         SCAN: begin
            if (rows_s != ROWS_IDLE) begin
               latch_d = rows_s;
               state_d = DEBOUNCE;
            end else if (div_q == DIV_LAST) begin
               col_d = col_q + 2'd1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rows_s != latch_q) begin
               state_d = SCAN;
            end else if (stable_done) begin
               if (single_low(latch_q)) begin
                  state_d = EMIT;
                  if (dec_code <= 4'd9) begin
                     if (dcnt_q < DIG_MAX) begin
                        key_d   = dec_code;
                        enter_d = 1'b1;
                        dcnt_d  = dcnt_q + 3'd1;
                     end
                  end else if (dec_code == KEY_HASH) begin
                     check_d = 1'b1;
                     dcnt_d  = 3'd0;
                  end else if (dec_code == KEY_STAR) begin
                     clear_d = 1'b1;
                     dcnt_d  = 3'd0;
                  end
               end else begin
                  state_d = WAIT_RELEASE;
               end
            end
         end
         EMIT: begin
            state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (stable_done) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   assign col_out   = ~(4'b0001 << col_q);
   assign key_in    = key_q;
   assign enter     = enter_q;
   assign check     = check_q;
   assign clear     = clear_q;
   assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner with a behavioural 4x4 key matrix.
module tb_keypad_entry_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_in;
   logic       enter;
   logic       check;
   logic       clear;
   logic [2:0] digit_cnt;

   logic [15:0] pressed;
   logic [3:0]  glitch;
   logic [9:0]  ev_q[$];
   logic [9:0]  exp_q[$];
   logic        prev_strobe;
   int          n_checks;
   int          n_errors;

   keypad_entry_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CYC (8),
      .NUM_DIGITS   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_in    (key_in),
      .enter     (enter),
      .check     (check),
      .clear     (clear),
      .digit_cnt (digit_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // key matrix: a pressed key pulls its row low while its column is driven
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
         end
         if (glitch[r]) row_in[r] = 1'b0;
      end
   end

   function automatic logic [9:0] mk_ev(input logic e, input logic ch, input logic cl,
                                        input logic [3:0] k, input logic [2:0] n);
      return {e, ch, cl, k, n};
   endfunction

   // strobe monitor: logs every strobe and checks exclusivity / no back-to-back
   initial prev_strobe = 1'b0;
   always @(negedge clk) begin
      if (rst_n && (enter || check || clear)) begin
         ev_q.push_back({enter, check, clear, key_in, digit_cnt});
         n_checks++;
         if (($countones({enter, check, clear}) != 1) || prev_strobe) begin
            $display("FAIL strobe_excl: got e/c/cl=%b%b%b prev=%b required single isolated strobe",
                     enter, check, clear, prev_strobe);
            n_errors++;
         end
      end
      prev_strobe = enter | check | clear;
   end

   // driver tasks
   task automatic press_key(input int r, input int c);
      pressed[r*4+c] = 1'b1;
      repeat (40) @(negedge clk);
      pressed = '0;
      repeat (24) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (col_out !== 4'b1110) begin $display("FAIL reset_col: got %b required 1110", col_out); n_errors++; end
      n_checks++;
      if (key_in !== 4'h0) begin $display("FAIL reset_key: got %h required 0", key_in); n_errors++; end
      n_checks++;
      if (enter !== 1'b0) begin $display("FAIL reset_enter: got %b required 0", enter); n_errors++; end
      n_checks++;
      if (check !== 1'b0) begin $display("FAIL reset_check: got %b required 0", check); n_errors++; end
      n_checks++;
      if (clear !== 1'b0) begin $display("FAIL reset_clear: got %b required 0", clear); n_errors++; end
      n_checks++;
      if (digit_cnt !== 3'd0) begin $display("FAIL reset_cnt: got %0d required 0", digit_cnt); n_errors++; end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_entry();
      ev_q.delete();
      exp_q.delete();
      press_key(0, 1); press_key(0, 1); press_key(0, 2); press_key(1, 0); press_key(3, 2);
      exp_q.push_back(mk_ev(1, 0, 0, 4'h2, 3'd1));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h2, 3'd2));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h3, 3'd3));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h4, 3'd4));
      exp_q.push_back(mk_ev(0, 1, 0, 4'h4, 3'd0));
      n_checks++;
      if (ev_q.size() != exp_q.size()) begin
         $display("FAIL entry_count: got %0d events required %0d", ev_q.size(), exp_q.size()); n_errors++;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= ev_q.size()) begin
            $display("FAIL entry_ev[%0d]: got none required %h", i, exp_q[i]); n_errors++;
         end else if (ev_q[i] !== exp_q[i]) begin
            $display("FAIL entry_ev[%0d]: got %h required %h", i, ev_q[i], exp_q[i]); n_errors++;
         end
      end
   endtask

   task automatic test_overflow();
      ev_q.delete();
      exp_q.delete();
      press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(1, 0); press_key(1, 1);
      press_key(3, 2);
      exp_q.push_back(mk_ev(1, 0, 0, 4'h1, 3'd1));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h2, 3'd2));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h3, 3'd3));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h4, 3'd4));
      exp_q.push_back(mk_ev(0, 1, 0, 4'h4, 3'd0));
      n_checks++;
      if (ev_q.size() != exp_q.size()) begin
         $display("FAIL ovf_count: got %0d events required %0d", ev_q.size(), exp_q.size()); n_errors++;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= ev_q.size()) begin
            $display("FAIL ovf_ev[%0d]: got none required %h", i, exp_q[i]); n_errors++;
         end else if (ev_q[i] !== exp_q[i]) begin
            $display("FAIL ovf_ev[%0d]: got %h required %h", i, ev_q[i], exp_q[i]); n_errors++;
         end
      end
   endtask

   task automatic test_glitch();
      logic [3:0] seen;
      int         found;
      ev_q.delete();
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         @(negedge clk);
         if (col_out == 4'b1101) found = 1;
      end
      n_checks++;
      if (found == 0) begin $display("FAIL glitch_col1: got col %b required 1101 within 40 cycles", col_out); n_errors++; end
      glitch[0] = 1'b1;
      repeat (5) @(negedge clk);
      glitch = '0;
      repeat (10) @(negedge clk);
      seen = 4'h0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         seen = seen | ~col_out;
      end
      n_checks++;
      if (seen !== 4'hF) begin $display("FAIL glitch_scan: got columns %b required 1111", seen); n_errors++; end
      n_checks++;
      if (ev_q.size() != 0) begin $display("FAIL glitch_strobe: got %0d events required 0", ev_q.size()); n_errors++; end
   endtask

   task automatic test_star();
      ev_q.delete();
      exp_q.delete();
      press_key(2, 0); press_key(0, 3); press_key(3, 0); press_key(2, 2);
      exp_q.push_back(mk_ev(1, 0, 0, 4'h7, 3'd1));
      exp_q.push_back(mk_ev(0, 0, 1, 4'h7, 3'd0));
      exp_q.push_back(mk_ev(1, 0, 0, 4'h9, 3'd1));
      n_checks++;
      if (ev_q.size() != exp_q.size()) begin
         $display("FAIL star_count: got %0d events required %0d", ev_q.size(), exp_q.size()); n_errors++;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= ev_q.size()) begin
            $display("FAIL star_ev[%0d]: got none required %h", i, exp_q[i]); n_errors++;
         end else if (ev_q[i] !== exp_q[i]) begin
            $display("FAIL star_ev[%0d]: got %h required %h", i, ev_q[i], exp_q[i]); n_errors++;
         end
      end
   endtask

   task automatic test_ghost();
      ev_q.delete();
      pressed[0*4+2] = 1'b1;
      pressed[1*4+2] = 1'b1;
      repeat (40) @(negedge clk);
      pressed = '0;
      repeat (24) @(negedge clk);
      n_checks++;
      if (ev_q.size() != 0) begin $display("FAIL ghost_strobe: got %0d events required 0", ev_q.size()); n_errors++; end
      press_key(2, 1);
      n_checks++;
      if (ev_q.size() != 1) begin
         $display("FAIL ghost_after_count: got %0d events required 1", ev_q.size()); n_errors++;
      end else begin
         n_checks++;
         if (ev_q[0] !== mk_ev(1, 0, 0, 4'h8, 3'd2)) begin
            $display("FAIL ghost_after_ev: got %h required %h", ev_q[0], mk_ev(1, 0, 0, 4'h8, 3'd2)); n_errors++;
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      int found;
      int first_k;
      int n_enter;
      ev_q.delete();
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         @(negedge clk);
         if (col_out == 4'b1110) found = 1;
      end
      pressed[1*4+1] = 1'b1;
      for (int k = 0; k < 40 && found == 1; k++) begin
         @(negedge clk);
         if (col_out == 4'b1101) found = 2;
      end
      n_checks++;
      if (found != 2) begin $display("FAIL rstdb_sync: got stage %0d required 2", found); n_errors++; end
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (col_out !== 4'b1110) begin $display("FAIL rstdb_col: got %b required 1110", col_out); n_errors++; end
      n_checks++;
      if ({enter, check, clear} !== 3'b000) begin
         $display("FAIL rstdb_strobe: got %b required 000", {enter, check, clear}); n_errors++;
      end
      n_checks++;
      if (digit_cnt !== 3'd0) begin $display("FAIL rstdb_cnt: got %0d required 0", digit_cnt); n_errors++; end
      n_checks++;
      if (key_in !== 4'h0) begin $display("FAIL rstdb_key: got %h required 0", key_in); n_errors++; end
      rst_n = 1'b1;
      first_k = -1;
      n_enter = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (enter) begin
            n_enter++;
            if (first_k < 0) first_k = k;
         end
      end
      pressed = '0;
      repeat (24) @(negedge clk);
      n_checks++;
      if (first_k != 15) begin $display("FAIL rstdb_latency: got cycle %0d required 15", first_k); n_errors++; end
      n_checks++;
      if (n_enter != 1) begin $display("FAIL rstdb_once: got %0d enters required 1", n_enter); n_errors++; end
      n_checks++;
      if (ev_q.size() != 1) begin
         $display("FAIL rstdb_count: got %0d events required 1", ev_q.size()); n_errors++;
      end else begin
         n_checks++;
         if (ev_q[0] !== mk_ev(1, 0, 0, 4'h5, 3'd1)) begin
            $display("FAIL rstdb_ev: got %h required %h", ev_q[0], mk_ev(1, 0, 0, 4'h5, 3'd1)); n_errors++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      pressed  = '0;
      glitch   = '0;
      rst_n    = 1'b0;
      test_reset();
      test_entry();
      test_overflow();
      test_glitch();
      test_star();
      test_ghost();
      test_reset_mid_debounce();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_entry_scanner.md
Name: keypad_entry_scanner

Overview:
- Front end of the door-lock path. Scans a 4x4 matrix keypad, synchronises and debounces the row lines, and decodes each accepted key press.
- Drives the password checker's digit/enter/check interface with single-cycle strobes.
- Caps each entry at NUM_DIGITS digits; the checker's index wraps, so the cap is enforced here.

Parameters:
- SCAN_DIV, 1000: clk cycles each column stays driven while scanning (>=2).
- DEBOUNCE_CYC, 20000: consecutive stable cycles needed to accept a press or a release (>=2).
- NUM_DIGITS, 4: maximum digits forwarded per entry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  out  4  column drive, one-hot active-low.
- key_in  out  4  digit value to checker; valid while enter is high, held otherwise.
- enter  out  1  one-cycle strobe, digit accepted.
- check  out  1  one-cycle strobe, '#' pressed.
- clear  out  1  one-cycle strobe, '*' pressed.
- digit_cnt  out  3  digits forwarded in the current entry.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values: col_out=4'b1110 (column 0), key_in=0, enter=check=clear=0, digit_cnt=0, state SCAN, all counters 0.
- row_in passes through a 2-flop synchroniser (rows_s). Both flops reset to 4'hF.
- SCAN:
  - Column index advances 0->1->2->3->0 every SCAN_DIV cycles.
  - If rows_s != 4'hF, freeze the column, latch rows_s, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE:
  - Counter increments while rows_s equals the latched pattern.
  - Any change returns to SCAN; the column index is unchanged and the divider restarts.
  - When the count reaches DEBOUNCE_CYC: exactly one row low -> EMIT; more than one row low (ghost/multi-press) -> WAIT_RELEASE with no strobe.
- EMIT (1 cycle): decode (row r, column c).
  - Layout: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
  - Digit, digit_cnt<NUM_DIGITS: key_in<=value, enter=1, digit_cnt+1.
  - Digit, digit_cnt==NUM_DIGITS: dropped, no strobe.
  - '#': check=1, digit_cnt<=0. Emitted for any digit_cnt, including 0.
  - '*': clear=1, digit_cnt<=0.
  - A-D: ignored.
  - Always go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Column stays frozen.
  - Requires rows_s==4'hF for DEBOUNCE_CYC consecutive cycles; any low resets the counter.
  - Then advance to the next column and go to SCAN.
- Strobes:
  - Registered outputs. enter, check and clear are mutually exclusive and never high for two consecutive cycles.
  - One physical press yields at most one strobe.
- Latency: a strobe asserts on cycle DEBOUNCE_CYC+1 after the cycle rows_s first shows the press. A bench using small parameters checks this cycle-exactly.
- Width rules: digit_cnt saturates at NUM_DIGITS. Counters are sized by $clog2 of their parameter and never wrap.
- A key held through reset deasserting is detected by the normal scan and accepted once.
- Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE: next cycle all state is at its reset values and no strobe is issued.

Decomposition:
- Shared package keypad_pkg:
  - state enum (SCAN, DEBOUNCE, EMIT, WAIT_RELEASE);
  - key codes KEY_A..KEY_D=4'hA..4'hD, KEY_STAR=4'hE, KEY_HASH=4'hF;
  - decode function (row, col) -> 4-bit code.
- One natural sub-module: keypad_row_sync. It holds the 2-flop synchroniser and the stable-pattern counter, and outputs rows_s and a stable_done pulse. It is instanced once; the FSM, column driver and digit counter stay in the top.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Press/release 2,2,3,4,#, each held 40 cycles -> enter with key_in 2,2,3,4, then check=1; digit_cnt 1,2,3,4,0.
- Five digits 1..5 then # -> four enters (1,2,3,4); fifth dropped with no strobe; then check.
- Row glitch low for 5 cycles on column 1 -> no strobe, scanning resumes.
- Press 7, then *, then 9 -> enter(7), clear with digit_cnt=0, enter(9) with digit_cnt=1.
- Rows 0 and 1 low together on column 2 -> no strobe; after release, scanning continues normally.
- rst_n low for 1 cycle mid-DEBOUNCE while '5' is held -> outputs reset, col_out=4'b1110; '5' still held is later accepted once (single enter, key_in=5).
